// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory arbiter
package dmem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CPU_RD = 2'd1;
    localparam logic [1:0] ST_DBG_RD = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - cpu/dbg/memory bus bundle; perf outputs under DMEM_ARB_PERF_EN
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_dbg_cnt;
`endif

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
`ifdef DMEM_ARB_PERF_EN
        , output perf_stall_cnt, perf_dbg_cnt
`endif
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
`ifdef DMEM_ARB_PERF_EN
        , input perf_stall_cnt, perf_dbg_cnt
`endif
    );
endinterface

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - saturating count of lost dbg arbitration cycles
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_CNT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_grant = (cnt == MAX_CNT);
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - fixed-priority cpu/dbg arbiter for single-port data memory
// Optional DMEM_ARB_PERF_EN adds stall and dbg-grant counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        owner;
    logic              idle;
    logic              force_dbg;
    logic              dbg_win;
    logic              cpu_win;
    logic              cpu_stall;
    logic              we_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Requests are only arbitrated in IDLE and never while reset is held.
    assign idle    = reset && (state == ST_IDLE);
    assign dbg_win = idle && bus.dbg_req && (!bus.cpu_req || force_dbg);
    assign cpu_win = idle && bus.cpu_req && !dbg_win;
    assign owner   = dbg_win ? OWN_DBG : (cpu_win ? OWN_CPU : OWN_NONE);

    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        case (owner)
            OWN_CPU: begin
                we_mux    = bus.cpu_we;
                addr_mux  = bus.cpu_addr;
                wdata_mux = bus.cpu_wdata;
            end
            OWN_DBG: begin
                we_mux    = bus.dbg_we;
                addr_mux  = bus.dbg_addr;
                wdata_mux = bus.dbg_wdata;
            end
            default: ;
        endcase
    end

    // Writes retire in the grant cycle; reads spend one cycle collecting data.
    always_comb begin
        state_nxt = ST_IDLE;
        if ((owner != OWN_NONE) && !we_mux) begin
            state_nxt = (owner == OWN_DBG) ? ST_DBG_RD : ST_CPU_RD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    dmem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk         (clk),
        .reset       (reset),
        .inc         (idle && bus.dbg_req && !dbg_win),
        .clr         (dbg_win || !bus.dbg_req),
        .force_grant (force_dbg)
    );

    assign cpu_stall = reset && bus.cpu_req && !(cpu_win && bus.cpu_we) && (state != ST_CPU_RD);

    assign bus.cpu_stall  = cpu_stall;
    assign bus.cpu_rdata  = (state == ST_CPU_RD) ? bus.mem_rdata : '0;
    assign bus.dbg_gnt    = dbg_win;
    assign bus.dbg_rvalid = (state == ST_DBG_RD);
    assign bus.dbg_rdata  = (state == ST_DBG_RD) ? bus.mem_rdata : '0;
    assign bus.mem_en     = (owner != OWN_NONE);
    assign bus.mem_we     = we_mux;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wdata  = wdata_mux;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] dbg_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            dbg_cnt_q   <= '0;
        end else begin
            if (cpu_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (dbg_win)   dbg_cnt_q   <= dbg_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_dbg_cnt   = dbg_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with behavioural model
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read memory seen by the arbiter.
    bit   [DW-1:0] ram [256];
    logic [DW-1:0] rdata_q = '0;
    assign bus.mem_rdata = rdata_q;
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= ram[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding read owner (0 none, 1 cpu, 2 dbg) and lost-cycle count.
    bit   [DW-1:0] golden [256];
    int            m_rd;
    int            m_cnt;
    logic [DW-1:0] m_rd_data;
    logic [31:0]   m_pstall, m_pdbg;
    logic          e_stall, e_gnt, e_rvalid, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_cpu_rdata, e_dbg_rdata;

    function automatic void model_reset();
        m_rd = 0; m_cnt = 0; m_rd_data = '0; m_pstall = '0; m_pdbg = '0;
    endfunction

    function automatic void model_eval();
        logic dwin, cwin;
        e_stall = 0; e_gnt = 0; e_rvalid = 0; e_en = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_cpu_rdata = '0; e_dbg_rdata = '0;
        dwin = 0; cwin = 0;
        if (reset) begin
            if (m_rd == 1) e_cpu_rdata = m_rd_data;
            if (m_rd == 2) begin e_rvalid = 1; e_dbg_rdata = m_rd_data; end
            if (m_rd == 0) begin
                dwin = bus.dbg_req && (!bus.cpu_req || m_cnt >= MW);
                cwin = bus.cpu_req && !dwin;
            end
            if (dwin) begin
                e_gnt = 1; e_en = 1; e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wdata = bus.dbg_wdata;
            end else if (cwin) begin
                e_en = 1; e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
            end
            e_stall = bus.cpu_req && (m_rd != 1) && !(cwin && bus.cpu_we);
        end
    endfunction

    function automatic void model_update();
        int nrd;
        if (!reset) begin model_reset(); return; end
        if (e_stall) m_pstall = m_pstall + 1;
        if (e_gnt)   m_pdbg   = m_pdbg + 1;
        if (m_rd == 0) m_cnt = (e_gnt || !bus.dbg_req) ? 0 : ((m_cnt < MW) ? m_cnt + 1 : MW);
        else if (!bus.dbg_req) m_cnt = 0;
        nrd = 0;
        if (e_en && e_we) golden[e_addr] = e_wdata;
        if (e_en && !e_we) begin
            nrd = e_gnt ? 2 : 1;
            m_rd_data = golden[e_addr];
        end
        m_rd = nrd;
    endfunction

    function automatic logic [108:0] exp_vec();
        return {e_stall, e_gnt, e_rvalid, e_en, e_we, e_addr, e_wdata, e_cpu_rdata, e_dbg_rdata};
    endfunction

    function automatic logic [108:0] act_vec();
        return {bus.cpu_stall, bus.dbg_gnt, bus.dbg_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr,
                bus.mem_wdata, bus.cpu_rdata, bus.dbg_rdata};
    endfunction

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
        #1;
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        drive(1, 1, 8'h12, 32'h1234, 1, 0, 8'h34, 32'h5678);
        checks++;
        if ({bus.cpu_stall, bus.dbg_gnt, bus.dbg_rvalid, bus.mem_en, bus.mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.cpu_stall, bus.dbg_gnt, bus.dbg_rvalid, bus.mem_en, bus.mem_we});
        end
        checks++;
        if ({bus.cpu_rdata, bus.dbg_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.cpu_rdata, bus.dbg_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_dbg_preload();
        logic [DW-1:0] tbl [10];
        int gnts = 0;
        tbl = '{32'h00000001, 32'h0fd76e10, 32'h2a5c13f7, 32'h3e881d02, 32'h5b0f9a44,
                32'h6d21c0e9, 32'h7fe34a18, 32'h9a06b3d5, 32'hb4472e61, 32'hc187a606};
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 1, AW'(i), tbl[i]);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL preload_cycle%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            if (bus.dbg_gnt === 1'b1 && bus.mem_we === 1'b1) gnts++;
            step();
        end
        checks++;
        if (gnts != 10) begin
            errors++;
            $display("FAIL preload_gnts: got %0d expected 10", gnts);
        end
        drive(0, 0, 0, 0, 1, 0, 8'd9, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.dbg_rvalid, bus.dbg_rdata} !== {1'b1, 32'hc187a606}) begin
            errors++;
            $display("FAIL preload_readback: got %b/%h expected 1/c187a606", bus.dbg_rvalid, bus.dbg_rdata);
        end
        step();
    endtask

    task automatic test_cpu_load();
        drive(1, 0, 8'd1, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.cpu_stall, bus.mem_en, bus.mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL load_issue: stall/en/we got %b expected 110", {bus.cpu_stall, bus.mem_en, bus.mem_we});
        end
        step();
        drive(1, 0, 8'd1, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.cpu_stall, bus.cpu_rdata} !== {1'b0, 32'h0fd76e10}) begin
            errors++;
            $display("FAIL load_data: got %b/%h expected 0/0fd76e10", bus.cpu_stall, bus.cpu_rdata);
        end
        step();
    endtask

    task automatic test_cpu_store();
        drive(1, 1, 8'd11, 32'h0fd76e00, 0, 0, 0, 0);
        checks++;
        if ({bus.cpu_stall, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b011, 8'd11}) begin
            errors++;
            $display("FAIL store_issue: got %b/%0d expected 011/11",
                     {bus.cpu_stall, bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        step();
        drive(0, 0, 0, 0, 1, 0, 8'd11, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.dbg_rvalid, bus.dbg_rdata} !== {1'b1, 32'h0fd76e00}) begin
            errors++;
            $display("FAIL store_readback: got %b/%h expected 1/0fd76e00", bus.dbg_rvalid, bus.dbg_rdata);
        end
        step();
    endtask

    task automatic test_simultaneous();
        drive(1, 0, 8'd2, 0, 1, 0, 8'd3, 0);
        checks++;
        if ({bus.dbg_gnt, bus.cpu_stall, bus.mem_en, bus.mem_addr} !== {3'b011, 8'd2}) begin
            errors++;
            $display("FAIL simul_cpu_wins: got %b/%0d expected 011/2",
                     {bus.dbg_gnt, bus.cpu_stall, bus.mem_en}, bus.mem_addr);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_contention();
        int lost = 0;
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(1, 0, AW'($urandom_range(0, 15)), 0, 1, 0, 8'd5, 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL contention_cycle%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
            if (bus.dbg_gnt === 1'b1) begin
                got = 1;
                checks++;
                if (bus.cpu_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL forced_gnt_stall: got %b expected 1", bus.cpu_stall);
                end
            end else if (bus.mem_en === 1'b1) begin
                lost++;
            end
            step();
        end
        checks++;
        if (!got || lost != MW) begin
            errors++;
            $display("FAIL starve_force: granted %0d after %0d lost cycles, expected 1 after %0d", got, lost, MW);
        end
        drive(1, 0, 8'd7, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.cpu_stall, bus.dbg_rvalid, bus.mem_en} !== 3'b110) begin
            errors++;
            $display("FAIL dbg_rd_cycle: stall/rvalid/en got %b expected 110", {bus.cpu_stall, bus.dbg_rvalid, bus.mem_en});
        end
        step();
        drive(1, 0, 8'd7, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.dbg_gnt, bus.mem_en, bus.mem_addr} !== {2'b01, 8'd7}) begin
            errors++;
            $display("FAIL cpu_resume: gnt/en got %b addr %0d expected 01 addr 7", {bus.dbg_gnt, bus.mem_en}, bus.mem_addr);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset_mid_read();
        drive(1, 0, 8'd3, 0, 1, 0, 8'd4, 0);
        step();
        drive(1, 0, 8'd3, 0, 1, 0, 8'd4, 0);
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.cpu_stall, bus.dbg_rvalid, bus.mem_en, bus.cpu_rdata} !== '0) begin
            errors++;
            $display("FAIL midread_reset: stall/rvalid/en %b rdata %h expected 000/0",
                     {bus.cpu_stall, bus.dbg_rvalid, bus.mem_en}, bus.cpu_rdata);
        end
`ifdef DMEM_ARB_PERF_EN
        checks++;
        if ({bus.perf_stall_cnt, bus.perf_dbg_cnt} !== 64'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", bus.perf_stall_cnt, bus.perf_dbg_cnt);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 8'd3, 0, 1, 0, 8'd4, 0);
        checks++;
        if ({bus.dbg_gnt, bus.mem_en, bus.mem_addr, bus.cpu_rdata} !== {2'b01, 8'd3, 32'd0}) begin
            errors++;
            $display("FAIL midread_reissue: gnt/en %b addr %0d rdata %h expected 01/3/0",
                     {bus.dbg_gnt, bus.mem_en}, bus.mem_addr, bus.cpu_rdata);
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_random();
        bit            dpend = 0;
        logic          dw = 0;
        logic [AW-1:0] da = '0;
        logic [DW-1:0] dd = '0;
        int            bad = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!dpend && ($urandom_range(0, 2) == 0)) begin
                dpend = 1;
                dw = 1'($urandom);
                da = AW'($urandom_range(0, 15));
                dd = $urandom;
            end
            drive(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 15)), $urandom,
                  dpend, dw, da, dd);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
`ifdef DMEM_ARB_PERF_EN
            checks++;
            if ({bus.perf_stall_cnt, bus.perf_dbg_cnt} !== {m_pstall, m_pdbg}) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random_perf%0d: got %0d/%0d expected %0d/%0d", i,
                                       bus.perf_stall_cnt, bus.perf_dbg_cnt, m_pstall, m_pdbg);
            end
`endif
            if (e_gnt) dpend = 0;
            step();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_dbg_preload();
        test_cpu_load();
        test_cpu_store();
        test_simultaneous();
        test_contention();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (cpu port) and a debug/loader port (dbg port) used to preload and inspect RAM.
- Sits between the MEM stage and the data memory unit.
- Arbitration is fixed-priority: cpu wins by default. A starvation counter forces a dbg grant after MAX_WAIT lost cycles.
- Drives cpu_stall to freeze the pipeline (PC and IF/ID/EX/MEM registers) while a cpu access is pending.

Parameters:
- ADDR_W, 8, word-address width into the data memory.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive cycles dbg may lose arbitration before it is forced through; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage has a load/store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid when cpu_stall=0 in state CPU_RD.
- cpu_stall  out  1  pipeline freeze request.
- dbg_req  in  1  debug request; held high until dbg_gnt.
- dbg_we, dbg_addr, dbg_wdata  in  1/ADDR_W/DATA_W  as for cpu.
- dbg_gnt  out  1  one-cycle pulse; request accepted.
- dbg_rvalid  out  1  one-cycle pulse, cycle after a dbg read grant.
- dbg_rdata  out  DATA_W  valid with dbg_rvalid.
- mem_en, mem_we  out  1  memory enable / write enable.
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to memory.
- mem_rdata  in  DATA_W  synchronous read data, 1-cycle latency.

Behaviour:
- Reset (reset=0, async): state=IDLE, starve_cnt=0; dbg_gnt, dbg_rvalid, mem_en, mem_we = 0; cpu_rdata, dbg_rdata = 0.
- cpu_stall is combinational: cpu_stall = cpu_req && !(cpu write granted this cycle) && !(state==CPU_RD). During reset, cpu_stall=0.
- FSM states: IDLE, CPU_RD, DBG_RD.
- IDLE, grant selection: dbg wins if dbg_req && (!cpu_req || starve_cnt==MAX_WAIT); otherwise cpu wins if cpu_req.
- IDLE, write grant: mem_en=1, mem_we=1. The write completes in the same cycle and the state stays IDLE.
- IDLE, read grant: mem_en=1, mem_we=0; next state is CPU_RD or DBG_RD.
- mem_addr/mem_wdata carry the winner's fields; they are 0 when no grant.
- dbg_gnt is asserted in the grant cycle for both reads and writes.
- CPU_RD: cpu_rdata=mem_rdata, cpu_stall=0; no new issue; return to IDLE. A cpu load therefore costs exactly 1 stall cycle; a store costs 0 if granted.
- DBG_RD: dbg_rvalid=1, dbg_rdata=mem_rdata; no new issue; return to IDLE.
- starve_cnt: increments (saturating at MAX_WAIT) each IDLE cycle where dbg_req=1 and dbg is not granted. It clears on dbg_gnt and also clears if dbg_req drops.
- A forced dbg grant while cpu_req=1 stalls the cpu that cycle. The cpu access is retried in the next IDLE cycle.
- cpu_req/dbg_req arriving in CPU_RD/DBG_RD: not accepted. cpu_req is only evaluated as the next instruction in IDLE; dbg waits and its counter does not advance in RD states.
- Reset mid-read: the in-flight read is dropped, no rvalid is issued, and the requester must reissue.
- Address arithmetic: none; addresses pass through unmodified with no range check (wrap is memory-side).

Optional Feature:
- DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_dbg_cnt[31:0].
  - perf_stall_cnt counts cycles with cpu_stall=1.
  - perf_dbg_cnt counts dbg_gnt pulses.
  - Both wrap modulo 2^32 and both reset to 0.
- Undefined: these ports and registers do not exist; arbitration timing is identical in both builds.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE=2'd0, CPU_RD=2'd1, DBG_RD=2'd2),
  - ADDR_W/DATA_W defaults,
  - the owner tag constants.
- Natural sub-module: dmem_starve_ctr (saturating counter with clear; outputs the force flag).
- The FSM and muxing stay in dmem_arbiter.

Test Plan:
- cpu load only: cpu_req=1, we=0, addr=1, ram[1]=0x0fd76e10 -> cpu_stall=1 for 1 cycle; next cycle cpu_rdata=0x0fd76e10, cpu_stall=0.
- cpu store only: cpu_req=1, we=1, addr=11, wdata=0x0fd76e00 -> cpu_stall=0, mem_we=1 the same cycle, ram[11]=0x0fd76e00.
- dbg preload with cpu idle: dbg writes ram[0..9] with the values 0x00000001 ... 0xc187a606 -> 10 dbg_gnt pulses in 10 cycles; a subsequent dbg read of addr 9 gives dbg_rvalid with 0xc187a606.
- Contention, MAX_WAIT=4: cpu_req held with continuous loads while dbg_req=1 -> dbg_gnt asserts exactly when starve_cnt reaches 4; cpu_stall=1 that cycle; cpu resumes next IDLE.
- Simultaneous req with starve_cnt=0: cpu wins; dbg_gnt=0; starve_cnt increments to 1.
- Reset asserted in CPU_RD: state goes to IDLE immediately; cpu_rdata=0, dbg_rvalid=0, starve_cnt=0; with the macro defined, perf counters read 0.
